// File: rtl/fmul_pipe_if.sv
// fmul_pipe_if - operand/result handshake bundle for fmul_pipe.
//   Parameters: EXP_W (exponent width), FRAC_W (stored fraction width),
//               TAG_W (sideband tag width).
//   Input side : in_valid/in_ready, a_*/b_* operand fields, in_tag.
//   Output side: out_valid/out_ready, out_sign/out_exp/out_frac, out_tag,
//                out_error/out_overflow/out_underflow.
//   master modport: operand scheduler / result consumer side.
//   slave  modport: the multiplier itself.
`timescale 1ns/1ps
interface fmul_pipe_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic              a_sign;
  logic              b_sign;
  logic [EXP_W-1:0]  a_exp;
  logic [EXP_W-1:0]  b_exp;
  logic [FRAC_W-1:0] a_frac;
  logic [FRAC_W-1:0] b_frac;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [FRAC_W-1:0] out_frac;
  logic [TAG_W-1:0]  out_tag;
  logic              out_error;
  logic              out_overflow;
  logic              out_underflow;

  modport master (
    output in_valid, a_sign, b_sign, a_exp, b_exp, a_frac, b_frac, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_frac, out_tag,
           out_error, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, a_sign, b_sign, a_exp, b_exp, a_frac, b_frac, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_frac, out_tag,
           out_error, out_overflow, out_underflow
  );
endinterface

// File: rtl/fmul_pipe.sv
// fmul_pipe - three-stage pipelined floating-point multiplier.
//   S1: operand classification, sign, biased exponent sum, tag.
//   S2: raw mantissa product.
//   S3: normalise, round, exception/overflow/underflow select; output regs.
//   All stages advance together when the output register is empty or being
//   drained (advance = ~out_valid | out_ready); in_ready equals advance.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset (clears valids and outputs)
//   bus   - fmul_pipe_if.slave operand/result handshake bundle
// Build option:
//   FMUL_RNE_EN defined   -> round-to-nearest-even
//   FMUL_RNE_EN undefined -> truncation (only the top product bits are kept)
`timescale 1ns/1ps
module fmul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fmul_pipe_if.slave  bus
);
  localparam int PW = 2*FRAC_W + 2;
  localparam int SW = EXP_W + 2;
`ifdef FMUL_RNE_EN
  localparam int KW = PW;
`else
  // truncation needs only the norm bit plus FRAC_W+1 bits below it
  localparam int KW = FRAC_W + 2;
`endif
  localparam logic signed [SW-1:0] BIAS = SW'((1 << (EXP_W-1)) - 1);
  localparam logic signed [SW-1:0] EMAX = SW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_INF, CLS_ZERO} cls_e;

  logic advance, accept;
  assign advance      = ~bus.out_valid | bus.out_ready;
  assign accept       = bus.in_valid & advance;
  assign bus.in_ready = advance;

  // ---------------- S1 ----------------
  logic                 v1_d, v1_q;
  cls_e                 cls1_d, cls1_q;
  logic                 sign1_d, sign1_q;
  logic signed [SW-1:0] exp1_d, exp1_q;
  logic [TAG_W-1:0]     tag1_d, tag1_q;
  logic [FRAC_W-1:0]    afrac1_d, afrac1_q, bfrac1_d, bfrac1_q;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  always_comb begin
    a_zero   = (bus.a_exp == '0);
    b_zero   = (bus.b_exp == '0);
    a_inf    = (&bus.a_exp) & (bus.a_frac == '0);
    b_inf    = (&bus.b_exp) & (bus.b_frac == '0);
    a_nan    = (&bus.a_exp) & (bus.a_frac != '0);
    b_nan    = (&bus.b_exp) & (bus.b_frac != '0);
    v1_d     = advance ? bus.in_valid : v1_q;
    cls1_d   = cls1_q;
    sign1_d  = sign1_q;
    exp1_d   = exp1_q;
    tag1_d   = tag1_q;
    afrac1_d = afrac1_q;
    bfrac1_d = bfrac1_q;
    if (accept) begin
      if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) cls1_d = CLS_NAN;
      else if (a_inf | b_inf)                                  cls1_d = CLS_INF;
      else if (a_zero | b_zero)                                cls1_d = CLS_ZERO;
      else                                                     cls1_d = CLS_NORM;
      sign1_d  = bus.a_sign ^ bus.b_sign;
      exp1_d   = $signed({2'b00, bus.a_exp}) + $signed({2'b00, bus.b_exp}) - BIAS;
      tag1_d   = bus.in_tag;
      afrac1_d = bus.a_frac;
      bfrac1_d = bus.b_frac;
    end
  end

  // ---------------- S2 ----------------
  logic                 v2_d, v2_q;
  cls_e                 cls2_d, cls2_q;
  logic                 sign2_d, sign2_q;
  logic signed [SW-1:0] exp2_d, exp2_q;
  logic [TAG_W-1:0]     tag2_d, tag2_q;
  logic [PW-1:0]        prod_full;
  logic [KW-1:0]        prod2_d, prod2_q;

  always_comb begin
    prod_full = PW'({1'b1, afrac1_q}) * PW'({1'b1, bfrac1_q});
    v2_d      = advance ? v1_q : v2_q;
    cls2_d    = cls2_q;
    sign2_d   = sign2_q;
    exp2_d    = exp2_q;
    tag2_d    = tag2_q;
    prod2_d   = prod2_q;
    if (advance & v1_q) begin
      cls2_d  = cls1_q;
      sign2_d = sign1_q;
      exp2_d  = exp1_q;
      tag2_d  = tag1_q;
      prod2_d = KW'(prod_full >> (PW - KW));
    end
  end

  // ---------------- S3 ----------------
  logic                 out_valid_d, out_valid_q;
  logic                 out_sign_d, out_sign_q;
  logic [EXP_W-1:0]     out_exp_d, out_exp_q;
  logic [FRAC_W-1:0]    out_frac_d, out_frac_q;
  logic [TAG_W-1:0]     out_tag_d, out_tag_q;
  logic                 out_err_d, out_err_q, out_ovf_d, out_ovf_q, out_unf_d, out_unf_q;
  logic                 norm;
  logic [FRAC_W-1:0]    mant, mant_r;
  logic signed [SW-1:0] e_n, e_r;
`ifdef FMUL_RNE_EN
  logic guard, sticky, round_up, carry;
`endif

  always_comb begin
    norm = prod2_q[KW-1];
    mant = norm ? prod2_q[KW-2 -: FRAC_W] : prod2_q[KW-3 -: FRAC_W];
    e_n  = exp2_q + $signed({{(SW-1){1'b0}}, norm});
`ifdef FMUL_RNE_EN
    guard    = norm ? prod2_q[FRAC_W]           : prod2_q[FRAC_W-1];
    sticky   = norm ? |prod2_q[FRAC_W-1:0]      : |prod2_q[FRAC_W-2:0];
    round_up = guard & (sticky | mant[0]);
    // a carry out leaves mant_r at zero, i.e. mantissa 10.0 -> 1.0 with e+1
    {carry, mant_r} = {1'b0, mant} + {{FRAC_W{1'b0}}, round_up};
    e_r = e_n + $signed({{(SW-1){1'b0}}, carry});
`else
    mant_r = mant;
    e_r    = e_n;
`endif
    out_valid_d = advance ? v2_q : out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_frac_d  = out_frac_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;
    if (advance & v2_q) begin
      out_tag_d  = tag2_q;
      out_sign_d = sign2_q;
      out_err_d  = 1'b0;
      out_ovf_d  = 1'b0;
      out_unf_d  = 1'b0;
      out_exp_d  = '0;
      out_frac_d = '0;
      case (cls2_q)
        CLS_NAN: begin
          out_sign_d = 1'b0;
          out_exp_d  = '1;
          out_frac_d = {1'b1, {(FRAC_W-1){1'b0}}};
          out_err_d  = 1'b1;
        end
        CLS_INF:  out_exp_d = '1;
        CLS_ZERO: out_exp_d = '0;
        default: begin
          if (e_r >= EMAX) begin
            out_exp_d = '1;
            out_ovf_d = 1'b1;
          end else if (e_r[SW-1] || (e_r == '0)) begin
            out_unf_d = 1'b1;
          end else begin
            out_exp_d  = e_r[EXP_W-1:0];
            out_frac_d = mant_r;
          end
        end
      endcase
    end
  end

  // valids and outputs are reset; internal datapath stages are not
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_frac_q  <= out_frac_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
    end
  end

  always_ff @(posedge clk) begin
    cls1_q   <= cls1_d;
    sign1_q  <= sign1_d;
    exp1_q   <= exp1_d;
    tag1_q   <= tag1_d;
    afrac1_q <= afrac1_d;
    bfrac1_q <= bfrac1_d;
    cls2_q   <= cls2_d;
    sign2_q  <= sign2_d;
    exp2_q   <= exp2_d;
    tag2_q   <= tag2_d;
    prod2_q  <= prod2_d;
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_sign      = out_sign_q;
  assign bus.out_exp       = out_exp_q;
  assign bus.out_frac      = out_frac_q;
  assign bus.out_tag       = out_tag_q;
  assign bus.out_error     = out_err_q;
  assign bus.out_overflow  = out_ovf_q;
  assign bus.out_underflow = out_unf_q;
endmodule

// File: tb/tb_fmul_pipe.sv
`timescale 1ns/1ps
module tb_fmul_pipe;
  localparam int EW = 8;
  localparam int FW = 23;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmul_pipe_if #(.EXP_W(EW), .FRAC_W(FW), .TAG_W(TW)) bus ();
  fmul_pipe #(.EXP_W(EW), .FRAC_W(FW), .TAG_W(TW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] word;
    logic [3:0]  tag;
    logic        err;
    logic        ovf;
    logic        unf;
    logic        lat;
    logic [31:0] acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur_exp;
  exp_t mon_e;
  int n_cmp = 0;
  int n_fail = 0;
  int ncyc = 0;
  logic stream_done;
  logic rnd_run;

  function automatic exp_t mk(input logic [31:0] w, input logic [3:0] t,
                              input logic er, input logic ov, input logic un, input logic lt);
    exp_t r;
    r = '0;
    r.word = w; r.tag = t; r.err = er; r.ovf = ov; r.unf = un; r.lat = lt;
    return r;
  endfunction

  // Reference: exact integer product, then round/normalise by value comparison.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    exp_t r;
    logic s, az, bz, ai, bi, an, bn;
    int ea, eb, e, k;
    longint unsigned ma, mb, p, q;
`ifdef FMUL_RNE_EN
    longint unsigned rem, half;
`endif
    r = '0;
    r.tag = t;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);  bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 0);  bi = (eb == 255) && (b[22:0] == 0);
    an = (ea == 255) && (a[22:0] != 0);  bn = (eb == 255) && (b[22:0] != 0);
    if (an || bn || (ai && bz) || (az && bi)) begin
      r.word = 32'h7FC00000; r.err = 1'b1;
    end else if (ai || bi) begin
      r.word = {s, 8'hFF, 23'h0};
    end else if (az || bz) begin
      r.word = {s, 31'h0};
    end else begin
      ma = (64'd1 << 23) | 64'(a[22:0]);
      mb = (64'd1 << 23) | 64'(b[22:0]);
      p  = ma * mb;
      e  = ea + eb - 127;
      k  = (p >= (64'd1 << 47)) ? 24 : 23;
      e  = e + (k - 23);
      q  = p >> k;
`ifdef FMUL_RNE_EN
      rem  = p - (q << k);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
`endif
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r.word = {s, 8'hFF, 23'h0}; r.ovf = 1'b1;
      end else if (e <= 0) begin
        r.word = {s, 31'h0}; r.unf = 1'b1;
      end else begin
        r.word = {s, 8'(e), q[22:0]};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(9))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(30, 1));
      3:       e = 8'($urandom_range(254, 225));
      default: e = 8'($urandom_range(154, 100));
    endcase
    f = ($urandom_range(5) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Scoreboard: push on accept, pop and compare on transfer.
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got word=%h tag=%0d, expected no result",
                   {bus.out_sign, bus.out_exp, bus.out_frac}, bus.out_tag);
        end else begin
          mon_e = sb_q.pop_front();
          if ({bus.out_sign, bus.out_exp, bus.out_frac, bus.out_tag,
               bus.out_error, bus.out_overflow, bus.out_underflow} !==
              {mon_e.word, mon_e.tag, mon_e.err, mon_e.ovf, mon_e.unf}) begin
            n_fail++;
            $display("FAIL result: got word=%h tag=%0d e/o/u=%b%b%b, expected word=%h tag=%0d e/o/u=%b%b%b",
                     {bus.out_sign, bus.out_exp, bus.out_frac}, bus.out_tag,
                     bus.out_error, bus.out_overflow, bus.out_underflow,
                     mon_e.word, mon_e.tag, mon_e.err, mon_e.ovf, mon_e.unf);
          end
          if (mon_e.lat) begin
            n_cmp++;
            if (ncyc - int'(mon_e.acc) != 3) begin
              n_fail++;
              $display("FAIL latency: got %0d cycles, expected 3", ncyc - int'(mon_e.acc));
            end
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_e = cur_exp;
        mon_e.acc = 32'(ncyc);
        sb_q.push_back(mon_e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t, input exp_t ex);
    bus.in_valid = 1'b1;
    bus.a_sign = a[31]; bus.a_exp = a[30:23]; bus.a_frac = a[22:0];
    bus.b_sign = b[31]; bus.b_exp = b[30:23]; bus.b_frac = b[22:0];
    bus.in_tag = t;
    cur_exp = ex;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_fail++;
    $display("FAIL accept_timeout: tag %0d not accepted, expected accept within 200 cycles", t);
    bus.in_valid = 1'b0;
  endtask

  task automatic issue_m(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    issue(a, b, t, model(a, b, t));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  logic [44:0] snap;

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a_sign = 1'b0; bus.a_exp = '0; bus.a_frac = '0;
    bus.b_sign = 1'b0; bus.b_exp = '0; bus.b_frac = '0;
    bus.in_tag = '0;
    cur_exp = '0;
    stream_done = 1'b0;
    rnd_run = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", 64'({bus.out_valid, bus.out_sign, bus.out_exp, bus.out_frac, bus.out_tag,
                            bus.out_error, bus.out_overflow, bus.out_underflow, bus.in_ready}), 64'd1);
    @(posedge clk); #1;

    // directed vectors
    issue(32'h3FC00000, 32'h40000000, 4'd5, mk(32'h40400000, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(32'h7F800000, 32'h00000000, 4'd1, mk(32'h7FC00000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(32'hFF800000, 32'h40000000, 4'd2, mk(32'hFF800000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h7F000000, 32'h7F000000, 4'd3, mk(32'h7F800000, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0));
    issue(32'h00800000, 32'h00800000, 4'd4, mk(32'h00000000, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0));
`ifdef FMUL_RNE_EN
    issue(32'h3F800001, 32'h3FC00000, 4'd6, mk(32'h3FC00002, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0));
`else
    issue(32'h3F800001, 32'h3FC00000, 4'd6, mk(32'h3FC00001, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0));
`endif
    issue(32'h7FC12345, 32'h3F800000, 4'd7, mk(32'h7FC00000, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(32'h80000000, 32'h40000000, 4'd8, mk(32'h80000000, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h7F800000, 32'hFF800000, 4'd9, mk(32'hFF800000, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(32'h00000001, 32'h7F800000, 4'd10, mk(32'h7FC00000, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0));
    issue(32'h3F800000, 32'hBF800000, 4'd11, mk(32'hBF800000, 4'd11, 1'b0, 1'b0, 1'b0, 1'b0));
    idle(6);
    chk("drain_directed", 64'(sb_q.size()), 64'd0);

    // stall ordering: tags 1..6, out_ready dropped two cycles in
    fork
      begin
        for (int t = 1; t <= 6; t++)
          issue_m({2'b00, 6'($urandom_range(63)), 24'($urandom)} | 32'h3E000000,
                  {2'b00, 6'($urandom_range(63)), 24'($urandom)} | 32'h3E000000, 4'(t));
        stream_done = 1'b1;
      end
    join_none
    repeat (2) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("stall_full", 64'({bus.out_valid, bus.in_ready}), 64'b10);
    snap = {bus.out_valid, bus.out_sign, bus.out_exp, bus.out_frac, bus.out_tag,
            bus.out_error, bus.out_overflow, bus.out_underflow, bus.in_ready};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold", 64'({bus.out_valid, bus.out_sign, bus.out_exp, bus.out_frac, bus.out_tag,
                             bus.out_error, bus.out_overflow, bus.out_underflow, bus.in_ready}),
          64'(snap));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && !stream_done; i++) @(posedge clk);
    chk("stream_done", 64'(stream_done), 64'd1);
    idle(10);
    chk("drain_stall", 64'(sb_q.size()), 64'd0);

    // randomized traffic with random backpressure
    rnd_run = 1'b1;
    fork
      begin
        while (rnd_run) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2, 1)));
      issue_m(rnd_fp(), rnd_fp(), 4'($urandom));
    end
    rnd_run = 1'b0;
    idle(20);
    chk("drain_random", 64'(sb_q.size()), 64'd0);

    // reset with three operations in flight
    issue_m(32'h3FC00000, 32'h40400000, 4'd12);
    issue_m(32'h40000000, 32'h40000000, 4'd13);
    issue_m(32'h3F800000, 32'h3F000000, 4'd14);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid", 64'({bus.out_valid, bus.out_sign, bus.out_exp, bus.out_frac, bus.out_tag,
                          bus.out_error, bus.out_overflow, bus.out_underflow}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_stale", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    issue_m(32'h40400000, 32'h40400000, 4'd15);
    idle(6);
    chk("drain_after_reset", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fmul_pipe.md
# fmul_pipe

Pipelined, parametrised floating-point multiplier; successor to the team's single-cycle combinational multiplier. Accepts IEEE-style operands of configurable exponent/fraction width through a valid/ready handshake, computes the product in a fixed three-stage pipeline with full backpressure, and returns a packed result with exception flags and an in-order sideband tag. Sits between the operand scheduler and the FPU writeback arbiter.

## Interface
- `EXP_W`, 8, exponent width; `BIAS` is derived internally as 2^(EXP_W-1)-1
- `FRAC_W`, 23, stored fraction width, hidden bit excluded
- `TAG_W`, 4, sideband tag width, passed through unchanged

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block accepts operands this cycle
- `a_sign`, `b_sign`  in  1  operand signs
- `a_exp`, `b_exp`  in  EXP_W  biased exponents
- `a_frac`, `b_frac`  in  FRAC_W  fractions
- `in_tag`  in  TAG_W  sideband tag
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_sign`  out  1  result sign
- `out_exp`  out  EXP_W  result biased exponent
- `out_frac`  out  FRAC_W  result fraction, hidden bit excluded
- `out_tag`  out  TAG_W  tag of this result
- `out_error`  out  1  invalid operation: inf×0 or NaN operand
- `out_overflow`  out  1  result saturated to infinity
- `out_underflow`  out  1  result flushed to zero

## Operation
- Classify each operand:
  - zero: exp==0; denormals are treated as zero
  - inf: exp all-ones, frac==0
  - NaN: exp all-ones, frac!=0
- Exception priority:
  1. NaN operand, or inf×zero: canonical qNaN, i.e. sign 0, exp all-ones, frac MSB=1 and other bits 0; `out_error`=1.
  2. inf×inf or inf×finite: inf with sign = a_sign^b_sign.
  3. zero×finite: signed zero. `out_underflow` stays 0 in this case.
- Normal path:
  - sign = a_sign^b_sign
  - product P = {1,a_frac}×{1,b_frac}, width 2·FRAC_W+2
  - norm = P[MSB]; when norm=1, P is shifted right by 1
  - e = a_exp + b_exp − BIAS + norm, computed signed in EXP_W+2 bits
- Rounding: see Configuration. A rounding carry out of the mantissa sets frac=0 and e=e+1. The overflow check uses this updated e.
- Overflow: e ≥ 2^EXP_W−1 gives inf with correct sign, `out_overflow`=1.
- Underflow: e ≤ 0 gives signed zero, `out_underflow`=1.
- At most one of error/overflow/underflow is set per result.

## Timing
- Pipeline stages:
  - S1 registers classification, sign, exponent sum and tag.
  - S2 registers the raw mantissa product.
  - S3 registers the normalised, rounded result and flags.
- Latency is 3 cycles from accept to `out_valid` when the pipeline is not stalled.
- Throughput is 1 result/cycle.
- Handshake:
  - `advance` = ~out_valid | out_ready.
  - `in_ready` = `advance` (combinational).
  - All stages shift together only when `advance`=1. Bubbles are not compressed.
  - Accept occurs when in_valid & in_ready. Transfer occurs when out_valid & out_ready.
- While out_valid=1 and out_ready=0: all outputs hold stable, in_ready=0, and no stage changes.
- Results leave in acceptance order. out_tag equals the in_tag that was accepted with the operands.
- Reset, including mid-operation, applies on the next rising edge:
  - all stage valids clear, so out_valid=0
  - out_sign, out_exp, out_frac, out_tag and all flags = 0
  - in-flight operations are discarded
  - in_ready=1 from the first cycle after reset deasserts
- Datapath registers load only on `advance`. Stage valid bits are the only registers that need reset for correct operation. Outputs are nonetheless reset to 0 as stated above.

## Configuration
- `FMUL_RNE_EN` defined: round-to-nearest-even.
  - Guard bit = first discarded bit; sticky = OR of the remaining discarded bits.
  - Round up if guard & (sticky | lsb).
- `FMUL_RNE_EN` undefined: truncate.
  - Discarded bits are dropped.
  - A rounding carry cannot occur.
- Exceptions, handshake and latency are identical in both builds.

## Test plan
All scenarios use the defaults EXP_W=8, FRAC_W=23, and are written as packed 32-bit a×b.
- 0x3FC00000×0x40000000 (1.5×2.0), tag 5 → 0x40400000, tag 5, no flags, out_valid exactly 3 cycles after accept.
- 0x7F800000×0x00000000 → 0x7FC00000, error=1. 0xFF800000×0x40000000 → 0xFF800000, no flags.
- 0x7F000000×0x7F000000 → 0x7F800000, overflow=1. 0x00800000×0x00800000 → 0x00000000, underflow=1.
- 0x3F800001×0x3FC00000 (exact tie): with FMUL_RNE_EN → 0x3FC00002; without it → 0x3FC00001.
- Stall ordering:
  1. Stream tags 1..6 with out_ready=0 from cycle 2.
  2. Check in_ready=0 after the pipeline fills, and check outputs hold stable while stalled.
  3. Release out_ready; check tags 1..6 exit in order with no loss or duplication.
- Reset mid-operation: assert rst_n=0 with 3 operations in flight → next cycle out_valid=0 and all outputs 0; after release, no stale result ever appears.
